// File: rtl/rf_test_pkg.sv
// -----------------------------------------------------------------------------
// rf_test_pkg
// Shared types and default sizes for the register-file test-access block.
//   state_t     : arbitration FSM states (PROC, SWITCH, ARB, EXEC, RESP)
//   DATA_W_DEF  : default register data width
//   ADDR_W_DEF  : default register index width
//   idx_w()     : width of a channel index, at least 1 bit
// -----------------------------------------------------------------------------
package rf_test_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic [2:0] {
    PROC   = 3'd0,
    SWITCH = 3'd1,
    ARB    = 3'd2,
    EXEC   = 3'd3,
    RESP   = 3'd4
  } state_t;

  // A single channel still needs a 1-bit index so that ports never collapse
  // to zero width.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker. The pointer names the most recently
// granted requester; the scan starts at pointer+1 and wraps, so that requester
// has the lowest priority. The pointer register lives in the parent.
// Ports:
//   req        in  [N-1:0]      request vector
//   ptr        in  [IDX_W-1:0]  last granted index
//   grant      out [N-1:0]      one-hot grant (all zero when no request)
//   grant_idx  out [IDX_W-1:0]  index of the granted requester
// -----------------------------------------------------------------------------
module rr_arbiter
  import rf_test_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic             w_found;
  logic [IDX_W-1:0] w_cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_cand    = '0;
    // k runs 1..N so the pointer itself is visited last.
    for (int k = 1; k <= N; k++) begin
      w_cand = IDX_W'((int'(ptr) + k) % N);
      if (!w_found && req[w_cand]) begin
        w_found        = 1'b1;
        grant[w_cand]  = 1'b1;
        grant_idx      = w_cand;
      end
    end
  end

endmodule

// File: rtl/regfile_test_access.sv
// -----------------------------------------------------------------------------
// regfile_test_access
// Arbitrates register-file access between the processor and N_CH test
// channels. In PROC the processor drives the regfile directly; raising `test`
// moves through SWITCH into ARB, where channels are granted round-robin, one
// request per three cycles (ARB accept, EXEC access, RESP response).
//
// Handshake: a channel raises ch_req_valid[i] and holds write/addr/wdata
// stable; the transfer happens in the single cycle where ch_req_valid[i] and
// ch_req_ready[i] are both 1. A channel may drop valid before that cycle.
// ch_rsp_valid[i] pulses exactly two cycles after its accept, with the result
// on ch_rsp_data (read data, or the echoed write data), held until the next
// response.
//
// Optional feature, macro RF_WRITE_MONITOR_EN: registered copy of every
// regfile write on mon_valid/mon_reg/mon_data. Without the macro those
// outputs are tied 0.
//
// Ports:
//   clock, reset                  clock, synchronous active-high reset
//   test                          level request for test mode
//   proc_we/wr_reg/rd_a/rd_b/wr_data   processor side
//   proc_stall                    1 whenever processor access is blocked
//   ch_req_valid/ready/write/addr/wdata   packed per-channel request
//   ch_rsp_valid, ch_rsp_data     one-hot response pulse, shared data
//   rf_we/wr_reg/rd_a/rd_b/wr_data, rf_rd_data_a/b   regfile side
//   mon_valid/mon_reg/mon_data    write monitor
//   dbg_state                     current FSM state (state_t encoding)
// -----------------------------------------------------------------------------
module regfile_test_access
  import rf_test_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int N_CH   = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     test,
  input  logic                     proc_we,
  input  logic [ADDR_W-1:0]        proc_wr_reg,
  input  logic [ADDR_W-1:0]        proc_rd_a,
  input  logic [ADDR_W-1:0]        proc_rd_b,
  input  logic [DATA_W-1:0]        proc_wr_data,
  output logic                     proc_stall,
  input  logic [N_CH-1:0]          ch_req_valid,
  output logic [N_CH-1:0]          ch_req_ready,
  input  logic [N_CH-1:0]          ch_req_write,
  input  logic [N_CH*ADDR_W-1:0]   ch_req_addr,
  input  logic [N_CH*DATA_W-1:0]   ch_req_wdata,
  output logic [N_CH-1:0]          ch_rsp_valid,
  output logic [DATA_W-1:0]        ch_rsp_data,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_wr_reg,
  output logic [ADDR_W-1:0]        rf_rd_a,
  output logic [ADDR_W-1:0]        rf_rd_b,
  output logic [DATA_W-1:0]        rf_wr_data,
  input  logic [DATA_W-1:0]        rf_rd_data_a,
  input  logic [DATA_W-1:0]        rf_rd_data_b,
  output logic                     mon_valid,
  output logic [ADDR_W-1:0]        mon_reg,
  output logic [DATA_W-1:0]        mon_data,
  output logic [2:0]               dbg_state
);

  localparam int IDX_W = idx_w(N_CH);

  state_t            r_state;
  state_t            w_next;
  logic [IDX_W-1:0]  r_ptr;
  logic [IDX_W-1:0]  r_gidx;
  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rsp_data;

  logic [N_CH-1:0]   w_grant;
  logic [IDX_W-1:0]  w_gidx;
  logic              w_any_req;
  logic              w_accept;
  logic [N_CH-1:0]   w_rsp_onehot;

  // Only port A is used for channel reads; port B is passed through for the
  // processor and its data never enters this block.
  logic w_unused_ok;
  assign w_unused_ok = ^{rf_rd_data_b, 1'b0};

  rr_arbiter #(.N(N_CH), .IDX_W(IDX_W)) u_arb (
    .req       (ch_req_valid),
    .ptr       (r_ptr),
    .grant     (w_grant),
    .grant_idx (w_gidx)
  );

  assign w_any_req = |ch_req_valid;
  assign w_accept  = (r_state == ARB) && w_any_req;

  // ---------------------------------------------------------------------------
  // FSM state register and request/response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= PROC;
      r_ptr      <= IDX_W'(N_CH - 1);
      r_gidx     <= '0;
      r_wr       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rsp_data <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_gidx  <= w_gidx;
        r_ptr   <= w_gidx;
        r_wr    <= ch_req_write[w_gidx];
        r_addr  <= ch_req_addr[int'(w_gidx)*ADDR_W +: ADDR_W];
        r_wdata <= ch_req_wdata[int'(w_gidx)*DATA_W +: DATA_W];
      end
      if (r_state == EXEC) begin
        r_rsp_data <= r_wr ? r_wdata : rf_rd_data_a;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      PROC:    w_next = test ? SWITCH : PROC;
      SWITCH:  w_next = test ? ARB : PROC;
      ARB: begin
        if (w_any_req)  w_next = EXEC;
        else if (!test) w_next = PROC;
      end
      EXEC:    w_next = RESP;
      RESP:    w_next = test ? ARB : PROC;
      default: w_next = PROC;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Regfile mux and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    rf_we      = 1'b0;
    rf_wr_reg  = proc_wr_reg;
    rf_rd_a    = proc_rd_a;
    rf_rd_b    = proc_rd_b;
    rf_wr_data = proc_wr_data;
    if (r_state == PROC) begin
      rf_we = proc_we;
    end else if (r_state == EXEC) begin
      rf_we      = r_wr;
      rf_wr_reg  = r_addr;
      rf_wr_data = r_wdata;
      rf_rd_a    = r_addr;
    end
  end

  always_comb begin
    w_rsp_onehot = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_rsp_onehot[i] = (r_state == RESP) && (int'(r_gidx) == i);
    end
  end

  assign proc_stall   = (r_state != PROC);
  assign ch_req_ready = w_grant & {N_CH{r_state == ARB}};
  assign ch_rsp_valid = w_rsp_onehot;
  assign ch_rsp_data  = r_rsp_data;
  assign dbg_state    = r_state;

  // ---------------------------------------------------------------------------
  // Write monitor
  // ---------------------------------------------------------------------------
`ifdef RF_WRITE_MONITOR_EN
  logic              r_mon_valid;
  logic [ADDR_W-1:0] r_mon_reg;
  logic [DATA_W-1:0] r_mon_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_mon_valid <= 1'b0;
      r_mon_reg   <= '0;
      r_mon_data  <= '0;
    end else begin
      r_mon_valid <= rf_we;
      if (rf_we) begin
        r_mon_reg  <= rf_wr_reg;
        r_mon_data <= rf_wr_data;
      end
    end
  end

  assign mon_valid = r_mon_valid;
  assign mon_reg   = r_mon_reg;
  assign mon_data  = r_mon_data;
`else
  assign mon_valid = 1'b0;
  assign mon_reg   = '0;
  assign mon_data  = '0;
`endif

endmodule

// File: tb/tb_regfile_test_access.sv
// -----------------------------------------------------------------------------
// tb_regfile_test_access
// Directed bench for regfile_test_access (DATA_W=32, ADDR_W=5, N_CH=2).
// Inputs change 1 ns after a rising edge; outputs are sampled on the falling
// edge. A small regfile model answers reads on port A. Monitor expectations
// follow RF_WRITE_MONITOR_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_regfile_test_access;
  import rf_test_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NC = 2;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic            reset;
  logic            test;
  logic            proc_we;
  logic [AW-1:0]   proc_wr_reg, proc_rd_a, proc_rd_b;
  logic [DW-1:0]   proc_wr_data;
  logic            proc_stall;
  logic [NC-1:0]   ch_req_valid, ch_req_ready, ch_req_write;
  logic [NC*AW-1:0] ch_req_addr;
  logic [NC*DW-1:0] ch_req_wdata;
  logic [NC-1:0]   ch_rsp_valid;
  logic [DW-1:0]   ch_rsp_data;
  logic            rf_we;
  logic [AW-1:0]   rf_wr_reg, rf_rd_a, rf_rd_b;
  logic [DW-1:0]   rf_wr_data, rf_rd_data_a, rf_rd_data_b;
  logic            mon_valid;
  logic [AW-1:0]   mon_reg;
  logic [DW-1:0]   mon_data;
  logic [2:0]      dbg_state;

  regfile_test_access #(.DATA_W(DW), .ADDR_W(AW), .N_CH(NC)) dut (
    .clock(clock), .reset(reset), .test(test),
    .proc_we(proc_we), .proc_wr_reg(proc_wr_reg), .proc_rd_a(proc_rd_a),
    .proc_rd_b(proc_rd_b), .proc_wr_data(proc_wr_data), .proc_stall(proc_stall),
    .ch_req_valid(ch_req_valid), .ch_req_ready(ch_req_ready),
    .ch_req_write(ch_req_write), .ch_req_addr(ch_req_addr),
    .ch_req_wdata(ch_req_wdata), .ch_rsp_valid(ch_rsp_valid),
    .ch_rsp_data(ch_rsp_data), .rf_we(rf_we), .rf_wr_reg(rf_wr_reg),
    .rf_rd_a(rf_rd_a), .rf_rd_b(rf_rd_b), .rf_wr_data(rf_wr_data),
    .rf_rd_data_a(rf_rd_data_a), .rf_rd_data_b(rf_rd_data_b),
    .mon_valid(mon_valid), .mon_reg(mon_reg), .mon_data(mon_data),
    .dbg_state(dbg_state)
  );

  // ---------------- regfile model ----------------
  logic [DW-1:0] regs [32];
  initial for (int i = 0; i < 32; i++) regs[i] = '0;
  always @(posedge clock) if (rf_we && rf_wr_reg != '0) regs[rf_wr_reg] <= rf_wr_data;
  assign rf_rd_data_a = regs[rf_rd_a];
  assign rf_rd_data_b = regs[rf_rd_b];

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic set_ch(input int ch, input logic v, input logic wr,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    ch_req_valid[ch] = v;
    ch_req_write[ch] = wr;
    ch_req_addr[ch*AW +: AW] = a;
    ch_req_wdata[ch*DW +: DW] = d;
  endtask

  logic [3:0] mon_en;
  logic [DW-1:0] exp_d;

  // ---------------- directed sequence ----------------
  initial begin
`ifdef RF_WRITE_MONITOR_EN
    mon_en = 4'd1;
`else
    mon_en = 4'd0;
`endif
    reset = 1'b1; test = 1'b0;
    proc_we = 1'b1; proc_wr_reg = 5'd3; proc_wr_data = 32'hDEADBEEF;
    proc_rd_a = 5'd0; proc_rd_b = 5'd0;
    ch_req_valid = '0; ch_req_write = '0; ch_req_addr = '0; ch_req_wdata = '0;

    // Reset state; processor passes straight through.
    cyc(); cyc();
    sample();
    chk("rst_state", dbg_state, 3'(PROC));
    chk("rst_rf_we", rf_we, 1'b1);
    chk("rst_rf_wr_reg", rf_wr_reg, 5'd3);
    chk("rst_rf_wr_data", rf_wr_data, 32'hDEADBEEF);
    chk("rst_stall", proc_stall, 1'b0);
    chk("rst_ready", ch_req_ready, 2'b00);
    chk("rst_rsp_valid", ch_rsp_valid, 2'b00);
    chk("rst_rsp_data", ch_rsp_data, 32'h0);
    chk("rst_mon_valid", mon_valid, 1'b0);

    // Processor write reg 7 = 0xA5; monitor copy one cycle later.
    cyc();
    reset = 1'b0; proc_wr_reg = 5'd7; proc_wr_data = 32'h000000A5;
    sample();
    chk("proc_rf_wr_reg", rf_wr_reg, 5'd7);
    cyc();
    proc_we = 1'b0;
    sample();
    chk("mon_valid_w7", mon_valid, mon_en[0]);
    chk("mon_reg_w7", mon_reg, mon_en[0] ? 5'd7 : 5'd0);
    chk("mon_data_w7", mon_data, mon_en[0] ? 32'hA5 : 32'h0);
    cyc();
    sample();
    chk("mon_valid_drop", mon_valid, 1'b0);

    // Test mode: ch0 write reg 5 = 0x12345678.
    test = 1'b1;
    set_ch(0, 1'b1, 1'b1, 5'd5, 32'h12345678);
    cyc();
    sample();
    chk("sw_state", dbg_state, 3'(SWITCH));
    chk("sw_stall", proc_stall, 1'b1);
    chk("sw_ready", ch_req_ready, 2'b00);
    cyc();
    sample();
    chk("w0_state_arb", dbg_state, 3'(ARB));
    chk("w0_ready", ch_req_ready, 2'b01);
    chk("w0_arb_rf_we", rf_we, 1'b0);
    cyc();
    set_ch(0, 1'b0, 1'b0, 5'd0, 32'h0);
    sample();
    chk("w0_exec_we", rf_we, 1'b1);
    chk("w0_exec_reg", rf_wr_reg, 5'd5);
    chk("w0_exec_data", rf_wr_data, 32'h12345678);
    chk("w0_exec_rsp", ch_rsp_valid, 2'b00);
    cyc();
    // ch1 read of reg 5 queued while ch0's response is out.
    set_ch(1, 1'b1, 1'b0, 5'd5, 32'h0);
    sample();
    chk("w0_rsp_valid", ch_rsp_valid, 2'b01);
    chk("w0_rsp_data", ch_rsp_data, 32'h12345678);
    chk("w0_mon_valid", mon_valid, mon_en[0]);
    chk("w0_mon_reg", mon_reg, mon_en[0] ? 5'd5 : 5'd0);

    // ch1 read.
    cyc();
    sample();
    chk("r1_ready", ch_req_ready, 2'b10);
    cyc();
    set_ch(1, 1'b0, 1'b0, 5'd0, 32'h0);
    sample();
    chk("r1_exec_we", rf_we, 1'b0);
    chk("r1_exec_rd_a", rf_rd_a, 5'd5);
    cyc();
    sample();
    chk("r1_rsp_valid", ch_rsp_valid, 2'b10);
    chk("r1_rsp_data", ch_rsp_data, 32'h12345678);

    // Both channels valid continuously: ch0, ch1, ch0, ch1, 3 cycles apart.
    set_ch(0, 1'b1, 1'b1, 5'd1, 32'h00000011);
    set_ch(1, 1'b1, 1'b1, 5'd2, 32'h00000022);
    for (int g = 0; g < 4; g++) begin
      cyc();
      sample();
      chk($sformatf("rr%0d_ready", g), ch_req_ready, (g % 2 == 0) ? 2'b01 : 2'b10);
      cyc();
      sample();
      chk($sformatf("rr%0d_exec_reg", g), rf_wr_reg, (g % 2 == 0) ? 5'd1 : 5'd2);
      cyc();
      sample();
      exp_d = (g % 2 == 0) ? 32'h11 : 32'h22;
      chk($sformatf("rr%0d_rsp_valid", g), ch_rsp_valid, (g % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("rr%0d_rsp_data", g), ch_rsp_data, exp_d);
    end

    // test drops the cycle after ready[0]; request completes, ch1 stays pending.
    cyc();
    sample();
    chk("drop_ready", ch_req_ready, 2'b01);
    cyc();
    test = 1'b0;
    set_ch(0, 1'b0, 1'b0, 5'd0, 32'h0);
    sample();
    chk("drop_exec_state", dbg_state, 3'(EXEC));
    chk("drop_exec_we", rf_we, 1'b1);
    cyc();
    sample();
    chk("drop_rsp_valid", ch_rsp_valid, 2'b01);
    chk("drop_rsp_stall", proc_stall, 1'b1);
    cyc();
    sample();
    chk("drop_proc_state", dbg_state, 3'(PROC));
    chk("drop_proc_stall", proc_stall, 1'b0);
    chk("drop_no_ready", ch_req_ready, 2'b00);
    cyc();
    sample();
    chk("drop_still_no_ready", ch_req_ready, 2'b00);

    // Reset during EXEC: request dropped, no response.
    test = 1'b1;
    cyc(); cyc();
    sample();
    chk("mid_ready", ch_req_ready, 2'b10);
    cyc();
    reset = 1'b1;
    sample();
    chk("mid_exec_state", dbg_state, 3'(EXEC));
    cyc();
    reset = 1'b0; test = 1'b0;
    set_ch(1, 1'b0, 1'b0, 5'd0, 32'h0);
    sample();
    chk("mid_rst_state", dbg_state, 3'(PROC));
    chk("mid_rst_rsp", ch_rsp_valid, 2'b00);
    chk("mid_rst_data", ch_rsp_data, 32'h0);
    chk("mid_rst_stall", proc_stall, 1'b0);
    cyc();
    sample();
    chk("mid_after_rsp", ch_rsp_valid, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
